// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversamples sclk/cs/mosi on clk, deserializes MSB-first
// words and presents them on a valid/ready register with overrun and frame-error pulses.
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_p1;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   word_done;
  logic [DATA_WIDTH-1:0]  shift_nxt;

  state_t                 state;
  logic [DATA_WIDTH-2:0]  shreg;
  logic [CNT_W-1:0]       cnt;

  // Synchronizer stage: equal depth on all three lines keeps mosi aligned with sclk edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_p1   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_p1   <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p1;
  // Only the first DATA_WIDTH-1 bits are stored; the last bit goes straight into the word
  assign shift_nxt = {shreg, mosi_s};
  assign word_done = (state == RECV) && sclk_rise && (cnt == LAST_BIT);

  // Receive FSM and output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      busy      <= ~cs_s;
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!cs_s) state <= RECV;
        end
        RECV: begin
          if (sclk_rise) begin
            shreg <= shift_nxt[DATA_WIDTH-2:0];
            cnt   <= word_done ? '0 : cnt + CNT_W'(1);
          end
          // A completing word wins over a simultaneous cs rise
          if (cs_s) begin
            state <= IDLE;
            if (!word_done) begin
              cnt <= '0;
              if (cnt != '0) begin
                frame_err <= 1'b1;
                shreg     <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_nxt;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: drives SPI mode-0 frames and compares delivered words and
// error pulses against a queue-based model of what the master sent.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       overrun;
  logic       frame_err;

  spi_slave_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed behaviour (monitor) and expected behaviour (model)
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int n_ovr = 0, n_ferr = 0;
  int exp_ovr = 0, exp_ferr = 0;
  int hp = 4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      wait_clk(hp);
      sclk = 1'b1;
      wait_clk(hp);
      sclk = 1'b0;
    end
  endtask

  task automatic begin_frame();
    cs = 1'b0;
    wait_clk(4);
  endtask

  task automatic end_frame();
    wait_clk(hp);
    cs = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_word(input logic [7:0] w, input bit expect_deliver);
    send_bits({24'h0, w}, 8);
    if (expect_deliver) exp_q.push_back(w);
  endtask

  task automatic compare_model(input string tag);
    int n;
    wait_clk(6);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_data"}, got_q[i], exp_q[i]);
    check({tag, "_overrun"}, n_ovr, exp_ovr);
    check({tag, "_frame_err"}, n_ferr, exp_ferr);
    got_q.delete();
    exp_q.delete();
  endtask

  // Monitor: records handshakes and pulses, and checks rx_data holds while pending
  initial begin
    logic       prev_pend = 1'b0;
    logic [7:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) check("rx_data_hold", rx_data, prev_data);
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (overrun) n_ovr++;
        if (frame_err) n_ferr++;
        prev_pend = rx_valid && !rx_ready;
        prev_data = rx_data;
      end
    end
  end

  initial begin
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; rx_ready = 1'b1;
    wait_clk(3);
    #1;
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(4);

    // Single word
    begin_frame();
    send_word(8'hA5, 1);
    end_frame();
    compare_model("a5");

    // Back-to-back words within one frame
    begin_frame();
    check("busy_start", busy, 1);
    send_word(8'h3C, 1);
    check("busy_between", busy, 1);
    send_word(8'hC3, 1);
    check("busy_end_word", busy, 1);
    end_frame();
    check("busy_after", busy, 0);
    compare_model("b2b");

    // Backpressure and overrun
    rx_ready = 1'b0;
    begin_frame();
    send_word(8'h11, 1);
    send_word(8'h22, 0);
    end_frame();
    exp_ovr++;
    #1;
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_kept", rx_data, 8'h11);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    wait_clk(2); #1;
    check("ovr_valid_clear", rx_valid, 0);
    check("ovr_data_stays", rx_data, 8'h11);
    compare_model("overrun");

    // Aborted frame, then a clean one
    begin_frame();
    send_bits(32'hFF, 5);
    end_frame();
    exp_ferr++;
    begin_frame();
    send_word(8'h7E, 1);
    end_frame();
    compare_model("frame_err");

    // Asynchronous reset mid-frame
    begin_frame();
    send_bits(32'h0F, 4);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_rx_data", rx_data, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_frame_err", frame_err, 0);
    wait_clk(3);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(4);
    cs = 1'b1;
    wait_clk(10);
    begin_frame();
    send_word(8'h81, 1);
    end_frame();
    compare_model("after_rst");

    // sclk activity with cs deasserted must be ignored
    mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_clk(hp); sclk = 1'b1;
      wait_clk(hp); sclk = 1'b0;
    end
    #1;
    check("cs_high_busy", busy, 0);
    check("cs_high_valid", rx_valid, 0);
    compare_model("cs_high");

    // Randomized frames: random timing, word count, data and optional aborted tail
    for (int it = 0; it < 8; it++) begin
      hp = $urandom_range(3, 6);
      begin_frame();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        send_word(8'($urandom_range(0, 255)), 1);
      if ($urandom_range(0, 1) == 1) begin
        send_bits($urandom, $urandom_range(1, 7));
        exp_ferr++;
      end
      end_frame();
      compare_model("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
